// File: rtl/mips_branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-cycle combinational lookup, training and stats on the clk edge.
// No backpressure: one resolved branch/jump is accepted every cycle that upd_valid is high.
module mips_branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lu_pc,
  output logic              lu_hit,
  output logic              lu_taken,
  output logic [ADDR_W-1:0] lu_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_jump,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              upd_mispredict,
  input  logic              inv_all,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [ENTRIES-1:0] r_valid;
  logic [ENTRIES-1:0] r_jmp;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [ADDR_W-1:0]  r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];
  logic [CNT_W-1:0]   r_miss_cnt;

  logic [IDX_W-1:0]  w_lu_idx;
  logic [TAG_W-1:0]  w_lu_tag;
  logic              w_lu_hit;
  logic [IDX_W-1:0]  w_upd_idx;
  logic [TAG_W-1:0]  w_upd_tag;
  logic              w_upd_hit;
  logic [1:0]        w_cur_ctr;
  logic [1:0]        w_ctr_inc;
  logic [1:0]        w_ctr_dec;
  logic              w_mispredict;
  logic              w_miss_sat;

  logic              w_wr_en;
  logic [TAG_W-1:0]  w_nxt_tag;
  logic [ADDR_W-1:0] w_nxt_target;
  logic [1:0]        w_nxt_ctr;
  logic              w_nxt_jmp;

  // Lookup path: pc[1:0] is dropped, index then tag
  assign w_lu_idx  = lu_pc[IDX_W+1:2];
  assign w_lu_tag  = lu_pc[ADDR_W-1:IDX_W+2];
  assign w_lu_hit  = r_valid[w_lu_idx] && (r_tag[w_lu_idx] == w_lu_tag);

  assign lu_hit    = w_lu_hit;
  assign lu_taken  = w_lu_hit & r_ctr[w_lu_idx][1];
  assign lu_target = w_lu_hit ? r_target[w_lu_idx] : '0;

  assign w_upd_idx = upd_pc[IDX_W+1:2];
  assign w_upd_tag = upd_pc[ADDR_W-1:IDX_W+2];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  assign w_cur_ctr = r_ctr[w_upd_idx];
  assign w_ctr_inc = (w_cur_ctr == 2'b11) ? 2'b11 : w_cur_ctr + 2'd1;
  assign w_ctr_dec = (w_cur_ctr == 2'b00) ? 2'b00 : w_cur_ctr - 2'd1;

  assign w_mispredict = upd_valid &
                        ((upd_pred_taken != upd_taken) |
                         (upd_taken & (upd_pred_target != upd_target)));
  assign upd_mispredict = w_mispredict;

  assign w_miss_sat = &r_miss_cnt;
  assign miss_cnt   = r_miss_cnt;

  // Jump entries stay pinned at strongly-taken; a not-taken miss never allocates
  always_comb begin
    w_wr_en      = 1'b0;
    w_nxt_tag    = w_upd_tag;
    w_nxt_target = r_target[w_upd_idx];
    w_nxt_ctr    = w_cur_ctr;
    w_nxt_jmp    = r_jmp[w_upd_idx];
    if (upd_valid && !inv_all) begin
      if (w_upd_hit) begin
        w_wr_en = 1'b1;
        if (r_jmp[w_upd_idx] || upd_jump) begin
          w_nxt_ctr    = 2'b11;
          w_nxt_jmp    = 1'b1;
          w_nxt_target = upd_target;
        end else if (upd_taken) begin
          w_nxt_ctr    = w_ctr_inc;
          w_nxt_target = upd_target;
        end else begin
          w_nxt_ctr    = w_ctr_dec;
        end
      end else if (upd_taken) begin
        w_wr_en      = 1'b1;
        w_nxt_target = upd_target;
        w_nxt_jmp    = upd_jump;
        w_nxt_ctr    = upd_jump ? 2'b11 : 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_jmp   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b00;
      end
    end else if (inv_all) begin
      r_valid <= '0;
    end else if (w_wr_en) begin
      r_valid[w_upd_idx]  <= 1'b1;
      r_jmp[w_upd_idx]    <= w_nxt_jmp;
      r_tag[w_upd_idx]    <= w_nxt_tag;
      r_target[w_upd_idx] <= w_nxt_target;
      r_ctr[w_upd_idx]    <= w_nxt_ctr;
    end
  end

  // Counts through inv_all cycles too; holds at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_miss_cnt <= '0;
    end else if (w_mispredict && !w_miss_sat) begin
      r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_branch_predictor.sv
// Table-driven bench for mips_branch_predictor; per-cycle expectations go through a scoreboard queue.
module tb_mips_branch_predictor;

  localparam int CNT_W = 4;

  logic        clk;
  logic        rst;
  logic [31:0] lu_pc;
  logic        lu_hit;
  logic        lu_taken;
  logic [31:0] lu_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_jump;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        upd_mispredict;
  logic        inv_all;
  logic [CNT_W-1:0] miss_cnt;

  mips_branch_predictor #(.ADDR_W(32), .ENTRIES(16), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .lu_pc           (lu_pc),
    .lu_hit          (lu_hit),
    .lu_taken        (lu_taken),
    .lu_target       (lu_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_jump        (upd_jump),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .upd_mispredict  (upd_mispredict),
    .inv_all         (inv_all),
    .miss_cnt        (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lu;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        uj;
    logic        upt;
    logic [31:0] uptgt;
    logic        inv;
    logic        eh;
    logic        et;
    logic [31:0] etgt;
    logic        emp;
  } vec_t;

  typedef struct {
    logic        h;
    logic        t;
    logic [31:0] tgt;
    logic        mp;
    logic [CNT_W-1:0] miss;
    int          id;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  logic [CNT_W-1:0] exp_miss;
  int n_chk;
  int n_fail;

  function automatic vec_t mk(input logic [31:0] lu, input logic uv, input logic [31:0] upc,
                              input logic ut, input logic [31:0] utgt, input logic uj,
                              input logic upt, input logic [31:0] uptgt, input logic inv,
                              input logic eh, input logic et, input logic [31:0] etgt,
                              input logic emp);
    vec_t v;
    v.lu = lu; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.uj = uj;
    v.upt = upt; v.uptgt = uptgt; v.inv = inv;
    v.eh = eh; v.et = et; v.etgt = etgt; v.emp = emp;
    return v;
  endfunction

  function automatic vec_t lk(input logic [31:0] lu, input logic eh, input logic et,
                              input logic [31:0] etgt);
    return mk(lu, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, eh, et, etgt, 1'b0);
  endfunction

  task automatic cmp(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec%0d: got 0x%0h expected 0x%0h", nm, id, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    lu_pc           = v.lu;
    upd_valid       = v.uv;
    upd_pc          = v.upc;
    upd_taken       = v.ut;
    upd_target      = v.utgt;
    upd_jump        = v.uj;
    upd_pred_taken  = v.upt;
    upd_pred_target = v.uptgt;
    inv_all         = v.inv;
  endtask

  task automatic push_exp(input vec_t v, input int id);
    exp_t e;
    e.h = v.eh; e.t = v.et; e.tgt = v.etgt; e.mp = v.emp; e.miss = exp_miss; e.id = id;
    sb.push_back(e);
    if (v.emp && rst) exp_miss = (exp_miss == '1) ? exp_miss : exp_miss + 1'b1;
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    cmp("lu_hit",         e.id, {31'b0, lu_hit},         {31'b0, e.h});
    cmp("lu_taken",       e.id, {31'b0, lu_taken},       {31'b0, e.t});
    cmp("lu_target",      e.id, lu_target,               e.tgt);
    cmp("upd_mispredict", e.id, {31'b0, upd_mispredict}, {31'b0, e.mp});
    cmp("miss_cnt",       e.id, {28'b0, miss_cnt},       {28'b0, e.miss});
  endtask

  task automatic apply(input vec_t v, input int id);
    @(negedge clk);
    drive(v);
    push_exp(v, id);
    #2;
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    exp_miss = '0;

    tbl.push_back(lk(32'h40, 0, 0, 32'h0));
    tbl.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 0, 32'h0,   0, 0, 0, 32'h0,   1));
    tbl.push_back(mk(32'h100, 0, 32'h100, 0, 32'h0,   0, 1, 32'h0,   0, 1, 1, 32'h200, 0));
    tbl.push_back(mk(32'h100, 1, 32'h100, 0, 32'h999, 0, 1, 32'h200, 0, 1, 1, 32'h200, 1));
    tbl.push_back(mk(32'h100, 1, 32'h100, 0, 32'h0,   0, 0, 32'h777, 0, 1, 0, 32'h200, 0));
    tbl.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 0, 32'h0,   0, 1, 0, 32'h200, 1));
    tbl.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 0, 32'h0,   0, 1, 0, 32'h200, 1));
    tbl.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 1, 32'h200, 0, 1, 1, 32'h200, 0));
    tbl.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 1, 32'h200, 0, 1, 1, 32'h200, 0));
    tbl.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 1, 32'h200, 0, 1, 1, 32'h200, 0));
    tbl.push_back(mk(32'h100, 1, 32'h100, 0, 32'h0,   0, 1, 32'h200, 0, 1, 1, 32'h200, 1));
    tbl.push_back(lk(32'h100, 1, 1, 32'h200));
    tbl.push_back(mk(32'h140, 1, 32'h140, 1, 32'h300, 0, 0, 32'h0,   0, 0, 0, 32'h0,   1));
    tbl.push_back(lk(32'h100, 0, 0, 32'h0));
    tbl.push_back(mk(32'h140, 1, 32'h180, 0, 32'h0,   0, 0, 32'h0,   0, 1, 1, 32'h300, 0));
    tbl.push_back(lk(32'h140, 1, 1, 32'h300));
    tbl.push_back(lk(32'h180, 0, 0, 32'h0));
    tbl.push_back(mk(32'h8,   1, 32'h8,   1, 32'h1000, 1, 0, 32'h0,    0, 0, 0, 32'h0,    1));
    tbl.push_back(mk(32'h8,   1, 32'h8,   0, 32'h1000, 0, 1, 32'h1000, 0, 1, 1, 32'h1000, 1));
    tbl.push_back(mk(32'h8,   1, 32'h8,   0, 32'h1000, 0, 1, 32'h1000, 0, 1, 1, 32'h1000, 1));
    tbl.push_back(lk(32'h8, 1, 1, 32'h1000));
    tbl.push_back(mk(32'h140, 1, 32'h20,  1, 32'h400, 0, 1, 32'h500, 1, 1, 1, 32'h300, 1));
    tbl.push_back(lk(32'h20,  0, 0, 32'h0));
    tbl.push_back(lk(32'h140, 0, 0, 32'h0));
    tbl.push_back(lk(32'h8,   0, 0, 32'h0));

    // Reset state, asserted from time zero
    rst = 1'b0;
    drive(lk(32'h40, 0, 0, 32'h0));
    #3;
    push_exp(lk(32'h40, 0, 0, 32'h0), -1);
    check_out();
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Counter saturation: 20 more mispredicts on a never-allocating not-taken miss
    for (int i = 0; i < 20; i++)
      apply(mk(32'h3C, 1, 32'h3C, 0, 32'h0, 0, 1, 32'h0, 0, 0, 0, 32'h0, 1), 100 + i);
    apply(lk(32'h3C, 0, 0, 32'h0), 120);
    cmp("miss_cnt_saturated", 120, {28'b0, miss_cnt}, 32'd15);

    // Retrain, then asynchronous reset mid-cycle
    apply(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 0, 32'h0, 0, 0, 0, 32'h0, 1), 121);
    apply(lk(32'h100, 1, 1, 32'h200), 122);
    #1;
    rst = 1'b0;
    exp_miss = '0;
    #1;
    push_exp(lk(32'h100, 0, 0, 32'h0), 123);
    check_out();

    // Update presented in the release cycle is accepted
    @(negedge clk);
    rst = 1'b1;
    drive(mk(32'h100, 1, 32'h100, 1, 32'h240, 0, 0, 32'h0, 0, 0, 0, 32'h0, 1));
    push_exp(mk(32'h100, 1, 32'h100, 1, 32'h240, 0, 0, 32'h0, 0, 0, 0, 32'h0, 1), 124);
    #2;
    check_out();
    apply(lk(32'h100, 1, 1, 32'h240), 125);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
